// File: rtl/fpmult_share_arbiter.sv
// fpmult_share_arbiter: round-robin sharing of one fixed-latency FP multiplier with tagged result return and flush.
// Optional perf counters (perf_issues, perf_conflicts) are built when FPMULT_ARB_PERF_EN is defined.
`ifndef DWIDTH
`define DWIDTH 16
`endif
module fpmult_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int TAGW = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*`DWIDTH-1:0] req_a,
  input  logic [NREQ*`DWIDTH-1:0] req_b,
  output logic [NREQ-1:0]         req_ready,
  output logic                    mul_valid,
  output logic [`DWIDTH-1:0]      mul_a,
  output logic [`DWIDTH-1:0]      mul_b,
  input  logic [`DWIDTH-1:0]      mul_result,
  input  logic [4:0]              mul_exc,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [`DWIDTH-1:0]      rsp_data,
  output logic [4:0]              rsp_exc,
  input  logic                    flush,
  output logic                    flush_done,
`ifdef FPMULT_ARB_PERF_EN
  output logic [15:0]             perf_issues,
  output logic [15:0]             perf_conflicts,
`endif
  output logic                    idle
);
  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam int CW = $clog2(LAT + 1);
  logic [1:0]           state_q, state_d;
  logic [TAGW-1:0]      ptr_q, ptr_d, gidx, idx, last_tag;
  logic [LAT-1:0]       v_q;
  logic [LAT*TAGW-1:0]  tag_q;
  logic [CW-1:0]        inflight_q, inflight_d;
  logic [NREQ-1:0]      rsp_valid_q;
  logic [`DWIDTH-1:0]   rsp_data_q;
  logic [4:0]           rsp_exc_q;
  logic                 grant_en, found;
  // Rotating priority scan starting at ptr_q; the first valid requester wins.
  always_comb begin
    grant_en  = (state_q == RUN) && !flush && !rst;
    req_ready = '0;
    gidx      = ptr_q;
    idx       = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = TAGW'((int'(ptr_q) + k) % NREQ);
      if (!found && grant_en && req_valid[idx]) begin
        found          = 1'b1;
        gidx           = idx;
        req_ready[idx] = 1'b1;
      end
    end
  end
  assign mul_valid  = found;
  assign mul_a      = found ? req_a[gidx*`DWIDTH +: `DWIDTH] : '0;
  assign mul_b      = found ? req_b[gidx*`DWIDTH +: `DWIDTH] : '0;
  assign ptr_d      = found ? ((gidx == TAGW'(NREQ - 1)) ? '0 : gidx + 1'b1) : ptr_q;
  assign last_tag   = tag_q[(LAT-1)*TAGW +: TAGW];
  assign inflight_d = inflight_q + CW'(mul_valid) - CW'(v_q[LAT-1]);
  assign state_d    = (state_q == RUN) ? (flush ? DRAIN : RUN) :
                      (state_q == DRAIN) ? ((inflight_q == '0) ? DONE : DRAIN) : RUN;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      ptr_q       <= '0;
      v_q         <= '0;
      tag_q       <= '0;
      inflight_q  <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_exc_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      v_q         <= (v_q << 1) | LAT'(mul_valid);
      tag_q       <= (tag_q << TAGW) | (LAT*TAGW)'(gidx);
      inflight_q  <= inflight_d;
      rsp_valid_q <= v_q[LAT-1] ? (NREQ'(1) << last_tag) : '0;
      if (v_q[LAT-1]) begin
        rsp_data_q <= mul_result;
        rsp_exc_q  <= mul_exc;
      end
    end
  end
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_exc    = rsp_exc_q;
  assign flush_done = (state_q == DONE);
  assign idle       = (state_q == RUN) && (inflight_q == '0);
`ifdef FPMULT_ARB_PERF_EN
  logic [15:0] issues_q, conflicts_q;
  always_ff @(posedge clk) begin
    if (rst || flush_done) begin
      issues_q    <= '0;
      conflicts_q <= '0;
    end else begin
      if (mul_valid && issues_q != 16'hFFFF) issues_q <= issues_q + 16'd1;
      if ($countones(req_valid) > 1 && conflicts_q != 16'hFFFF) conflicts_q <= conflicts_q + 16'd1;
    end
  end
  assign perf_issues    = issues_q;
  assign perf_conflicts = conflicts_q;
`endif
endmodule

// File: tb/tb_fpmult_share_arbiter.sv
// tb_fpmult_share_arbiter: directed bench with a behavioural fp16 multiplier (LAT=4, NREQ=4).
`ifndef DWIDTH
`define DWIDTH 16
`endif
module tb_fpmult_share_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 4;
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0]    req_valid, req_ready, rsp_valid;
  logic [NREQ*16-1:0] req_a, req_b;
  logic               mul_valid, flush, flush_done, idle;
  logic [15:0]        mul_a, mul_b, mul_result, rsp_data;
  logic [4:0]         mul_exc, rsp_exc;
`ifdef FPMULT_ARB_PERF_EN
  logic [15:0]        perf_issues, perf_conflicts;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  fpmult_share_arbiter #(.NREQ(NREQ), .LAT(LAT), .TAGW(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .mul_exc(mul_exc), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_exc(rsp_exc), .flush(flush), .flush_done(flush_done),
`ifdef FPMULT_ARB_PERF_EN
    .perf_issues(perf_issues), .perf_conflicts(perf_conflicts),
`endif
    .idle(idle)
  );
  // fp16 multiply for normal operands, truncating; zero exponent is treated as zero.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic [21:0] p;
    logic [6:0]  e;
    logic        s;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = {2'b0, a[14:10]} + {2'b0, b[14:10]} - 7'd15;
    if (p[21]) begin
      p = p >> 1;
      e = e + 7'd1;
    end
    return {s, e[4:0], p[19:10]};
  endfunction
  logic [15:0] mp [LAT];
  logic [4:0]  me [LAT];
  always @(posedge clk) begin
    mp[0] <= fmul(mul_a, mul_b);
    me[0] <= {4'b0, (mul_a[14:0] == 15'd0) || (mul_b[14:0] == 15'd0)};
    for (int i = 1; i < LAT; i++) begin
      mp[i] <= mp[i-1];
      me[i] <= me[i-1];
    end
  end
  assign mul_result = mp[LAT-1];
  assign mul_exc    = me[LAT-1];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic setop(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask
  logic [15:0] ea [4];
  logic [15:0] er [4];
  logic [3:0]  one;
  logic [3:0]  exp_rdy [13];
  logic [3:0]  exp_rsp [13];
  logic [3:0]  pend;
  logic        got;
  initial begin
    ea  = '{16'h3C00, 16'hC000, 16'h4200, 16'h3E00};
    er  = '{16'h4000, 16'hC400, 16'h3E00, 16'h4080};
    one = 4'b0001;
    exp_rdy = '{4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h1, 4'h2, 4'h4};
    exp_rsp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; flush = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_exc", rsp_exc, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_idle", idle, 1);
    cyc();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_mul_valid", mul_valid, 0);
    // single request to requester 2
    cyc();
    rst = 1'b0;
    req_valid = 4'b0100;
    setop(2, 16'h3C00, 16'h4000);
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_mul_valid", mul_valid, 1);
    chk("single_mul_a", mul_a, 16'h3C00);
    chk("single_mul_b", mul_b, 16'h4000);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("single_rsp_valid_c%0d", c), rsp_valid, (c == 5) ? 4'b0100 : 4'b0000);
      if (c == 1) chk("single_busy", idle, 0);
    end
    chk("single_rsp_data", rsp_data, 16'h4000);
    chk("single_rsp_exc", rsp_exc, 0);
    chk("single_idle_back", idle, 1);
    // zero operand on requester 0: pointer wraps from 3, exception flag routed back
    cyc();
    req_valid = 4'b0001;
    setop(0, 16'h0000, 16'h4000);
    @(negedge clk);
    chk("zero_ready", req_ready, 4'b0001);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      req_valid = '0;
      @(negedge clk);
      chk($sformatf("zero_rsp_valid_c%0d", c), rsp_valid, (c == 5) ? 4'b0001 : 4'b0000);
    end
    chk("zero_rsp_data", rsp_data, 16'h0000);
    chk("zero_rsp_exc", rsp_exc, 5'd1);
    // all four valid from reset
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) setop(i, ea[i], (i == 2) ? 16'h3800 : (i == 3) ? 16'h3E00 : 16'h4000);
    req_valid = 4'b1111;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 13; k++) begin
      if (k > 0) cyc();
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      chk($sformatf("rr_ready_k%0d", k), req_ready, (k < 8) ? (one << (k % 4)) : 4'b0000);
      chk($sformatf("rr_mul_valid_k%0d", k), mul_valid, (k < 8) ? 1 : 0);
      if (k < 8) chk($sformatf("rr_mul_a_k%0d", k), mul_a, ea[k % 4]);
      chk($sformatf("rr_rsp_valid_k%0d", k), rsp_valid, (k >= 5) ? (one << ((k - 5) % 4)) : 4'b0000);
      if (k >= 5) chk($sformatf("rr_rsp_data_k%0d", k), rsp_data, er[(k - 5) % 4]);
    end
    // requester 1 always valid, requester 3 alternating
    for (int c = 0; c < 8; c++) begin
      cyc();
      req_valid = (c % 2 == 1) ? 4'b1010 : 4'b0010;
      @(negedge clk);
      chk($sformatf("fair_ready_c%0d", c), req_ready, (c % 2 == 1) ? 4'b1000 : 4'b0010);
    end
    cyc();
    req_valid = '0;
    repeat (4) cyc();
    @(negedge clk);
    chk("fair_last_rsp", rsp_valid, 4'b1000);
    chk("fair_last_data", rsp_data, 16'h4080);
    chk("fair_idle", idle, 1);
    // flush with three ops in flight, then four more ops before a reset
    for (int k = 0; k < 13; k++) begin
      cyc();
      req_valid = 4'b1111;
      flush = (k == 3);
      @(negedge clk);
      chk($sformatf("fl_ready_k%0d", k), req_ready, exp_rdy[k]);
      chk($sformatf("fl_rsp_valid_k%0d", k), rsp_valid, exp_rsp[k]);
      chk($sformatf("fl_done_k%0d", k), flush_done, (k == 8) ? 1 : 0);
      chk($sformatf("fl_idle_k%0d", k), idle, (k == 0 || k == 9) ? 1 : 0);
      if (k >= 5 && k <= 7) chk($sformatf("fl_rsp_data_k%0d", k), rsp_data, er[k - 5]);
    end
    cyc();
    rst = 1'b1;
    req_valid = '0;
    flush = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp_c13", rsp_valid, 0);
    for (int c = 14; c < 20; c++) begin
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk($sformatf("mid_rst_rsp_c%0d", c), rsp_valid, 0);
      if (c == 14) begin
        chk("mid_rst_idle", idle, 1);
        chk("mid_rst_data", rsp_data, 0);
        chk("mid_rst_exc", rsp_exc, 0);
        chk("mid_rst_mul_valid", mul_valid, 0);
        chk("mid_rst_flush_done", flush_done, 0);
      end
    end
    cyc();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
`ifdef FPMULT_ARB_PERF_EN
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = flush_done;
    end
    chk("perf_flush_done_seen", got, 1);
    cyc();
    @(negedge clk);
    chk("perf_clear_issues", perf_issues, 0);
    chk("perf_clear_conflicts", perf_conflicts, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      req_valid = one << (i % 4);
    end
    for (int j = 0; j < 2; j++) begin
      cyc();
      req_valid = 4'b0011;
      @(negedge clk);
      pend = req_valid & ~req_ready;
      cyc();
      req_valid = pend;
    end
    cyc();
    req_valid = '0;
    cyc();
    @(negedge clk);
    chk("perf_issues", perf_issues, 16'd10);
    chk("perf_conflicts", perf_conflicts, 16'd2);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = flush_done;
    end
    chk("perf_flush2_seen", got, 1);
    cyc();
    @(negedge clk);
    chk("perf_cleared_issues", perf_issues, 0);
    chk("perf_cleared_conflicts", perf_conflicts, 0);
`endif
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
